pattern_engine: RTL

PATTERN_ENGINE -- requirements
Module: pattern_engine

---
 rtl/pattern_engine_if.sv | 26 ++
 rtl/pattern_engine.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/pattern_engine_if.sv
// Port bundle for pattern_engine: incoming syncs and pattern request, aligned video out.
interface pattern_engine_if #(
    parameter int VIDEO_WIDTH = 3
);
    // No handshake: every input is sampled on every clock and every output is
    // valid on every clock, carrying the pixel whose syncs were sampled two clocks earlier.
    logic [2:0]             i_pattern;
    logic                   i_hsync;
    logic                   i_vsync;
    logic                   o_hsync;
    logic                   o_vsync;
    logic [VIDEO_WIDTH-1:0] o_red_video;
    logic [VIDEO_WIDTH-1:0] o_green_video;
    logic [VIDEO_WIDTH-1:0] o_blue_video;
    logic [2:0]             o_pattern_active;

    modport master (
        output i_pattern, i_hsync, i_vsync,
        input  o_hsync, o_vsync, o_red_video, o_green_video, o_blue_video, o_pattern_active
    );

    modport slave (
        input  i_pattern, i_hsync, i_vsync,
        output o_hsync, o_vsync, o_red_video, o_green_video, o_blue_video, o_pattern_active
    );
endinterface

// File: rtl/pattern_engine.sv
// Video test-pattern generator: raster counters, per-frame pattern latch, bouncing box,
// two-stage pipeline (counters + sync delay, then registered colour select).
module pattern_engine #(
    parameter int VIDEO_WIDTH  = 3,
    parameter int TOTAL_COLS   = 800,
    parameter int TOTAL_ROWS   = 525,
    parameter int ACTIVE_COLS  = 640,
    parameter int ACTIVE_ROWS  = 480,
    parameter int CHECKER_LOG2 = 5,
    parameter int BOX_SIZE     = 32
) (
    input logic              i_clk,
    input logic              i_rst_n,
    pattern_engine_if.slave  vid
);
    typedef logic [9:0] cnt_t;

    localparam cnt_t BAR_W   = cnt_t'(ACTIVE_COLS / 8);
    localparam cnt_t X_LIMIT = cnt_t'(ACTIVE_COLS - BOX_SIZE);
    localparam cnt_t Y_LIMIT = cnt_t'(ACTIVE_ROWS - BOX_SIZE);

    cnt_t       col, row, col_next, row_next;
    cnt_t       box_x, box_y, bar;
    logic       dir_x, dir_y;
    logic       started, hsync_d1, vsync_d1;
    logic       frame_start, in_active, in_box, use_ramp;
    logic [2:0] pattern_active, mask;
    logic [10:0] step_x, step_y;
    logic [VIDEO_WIDTH-1:0] red_d, green_d, blue_d;

    // Returns {next_dir, next_pos}; the position holds on the frame where the direction flips.
    function automatic logic [10:0] box_step(input cnt_t pos, input logic dir, input cnt_t limit);
        logic [10:0] res;
        res = {dir, pos};
        if (dir) begin
            if (pos == limit) res = {1'b0, pos};
            else              res = {1'b1, pos + 10'd1};
        end else begin
            if (pos == '0)    res = {1'b1, pos};
            else              res = {1'b0, pos - 10'd1};
        end
        return res;
    endfunction

    // The first clock out of reset and any vsync rising edge both start a new frame.
    always_comb begin
        col_next = col + 10'd1;
        row_next = row;
        if (!started || (!vsync_d1 && vid.i_vsync)) begin
            col_next = '0;
            row_next = '0;
        end else if (col == cnt_t'(TOTAL_COLS - 1)) begin
            col_next = '0;
            row_next = (row == cnt_t'(TOTAL_ROWS - 1)) ? '0 : row + 10'd1;
        end
        frame_start = (col_next == '0) && (row_next == '0);
        step_x      = box_step(box_x, dir_x, X_LIMIT);
        step_y      = box_step(box_y, dir_y, Y_LIMIT);
    end

    always_comb begin
        mask      = 3'b000;
        use_ramp  = 1'b0;
        bar       = col / BAR_W;
        in_active = (col < cnt_t'(ACTIVE_COLS)) && (row < cnt_t'(ACTIVE_ROWS));
        in_box    = (col >= box_x) && ({1'b0, col} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                    (row >= box_y) && ({1'b0, row} < {1'b0, box_y} + 11'(BOX_SIZE));
        case (pattern_active)
            3'd1: mask = 3'b100;
            3'd2: mask = 3'b010;
            3'd3: mask = 3'b001;
            3'd4: mask = {3{col[CHECKER_LOG2] ^ row[CHECKER_LOG2]}};
            3'd5: begin
                case (bar)
                    10'd0:   mask = 3'b111;
                    10'd1:   mask = 3'b110;
                    10'd2:   mask = 3'b011;
                    10'd3:   mask = 3'b010;
                    10'd4:   mask = 3'b101;
                    10'd5:   mask = 3'b100;
                    10'd6:   mask = 3'b001;
                    default: mask = 3'b000;
                endcase
            end
            3'd6:    use_ramp = 1'b1;
            3'd7:    mask = {3{in_box}};
            default: mask = 3'b000;
        endcase
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (in_active) begin
            if (use_ramp) begin
                red_d   = col[VIDEO_WIDTH+3:4];
                green_d = col[VIDEO_WIDTH+3:4];
                blue_d  = col[VIDEO_WIDTH+3:4];
            end else begin
                red_d   = {VIDEO_WIDTH{mask[2]}};
                green_d = {VIDEO_WIDTH{mask[1]}};
                blue_d  = {VIDEO_WIDTH{mask[0]}};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            started           <= 1'b0;
            col               <= '0;
            row               <= '0;
            hsync_d1          <= 1'b0;
            vsync_d1          <= 1'b0;
            pattern_active    <= '0;
            box_x             <= '0;
            box_y             <= '0;
            dir_x             <= 1'b1;
            dir_y             <= 1'b1;
            vid.o_hsync       <= 1'b0;
            vid.o_vsync       <= 1'b0;
            vid.o_red_video   <= '0;
            vid.o_green_video <= '0;
            vid.o_blue_video  <= '0;
        end else begin
            started  <= 1'b1;
            col      <= col_next;
            row      <= row_next;
            hsync_d1 <= vid.i_hsync;
            vsync_d1 <= vid.i_vsync;
            if (frame_start) begin
                pattern_active <= vid.i_pattern;
                {dir_x, box_x} <= step_x;
                {dir_y, box_y} <= step_y;
            end
            vid.o_hsync       <= hsync_d1;
            vid.o_vsync       <= vsync_d1;
            vid.o_red_video   <= red_d;
            vid.o_green_video <= green_d;
            vid.o_blue_video  <= blue_d;
        end
    end

    assign vid.o_pattern_active = pattern_active;
endmodule
